// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential word reads to the instruction SRAM,
// buffers returned words in a small queue and hands them to decode via valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4,
  parameter int          MEM_AW   = 12
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mbus_read,
  output logic              mbus_write,
  output logic [MEM_AW-1:0] mbus_addr,
  output logic [3:0]        mbus_byte_sel,
  output logic [31:0]       mbus_data_d,
  input  logic              mbus_ready,
  input  logic [31:0]       mbus_data_q,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc,
  input  logic              inst_ready
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] QDEPTH_LIM = (CW+1)'(QDEPTH);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state;
  logic [31:0]     pc;
  logic [31:0]     inflight_pc;
  logic            inflight;
  logic            kill;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     q_inst [QDEPTH];
  logic [31:0]     q_pc   [QDEPTH];

  logic [CW:0]     occupancy;
  logic            issue_ok;
  logic            push;
  logic            pop;

  // The in-flight slot is reserved in the queue so a returning word always fits.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign issue_ok  = fetch_en & ~redirect_valid & (occupancy < QDEPTH_LIM);
  assign push      = mbus_ready & inflight & ~kill;
  assign pop       = inst_valid & inst_ready;

  assign mbus_read     = issue_ok & ~rst;
  assign mbus_write    = 1'b0;
  assign mbus_byte_sel = 4'b0000;
  assign mbus_data_d   = 32'h0000_0000;
  assign mbus_addr     = pc[MEM_AW+1:2];

  assign inst_valid = (count != {CW{1'b0}});
  assign inst       = q_inst[rd_ptr];
  assign inst_pc    = q_pc[rd_ptr];

  // PC, in-flight tracking and fetch queue; a redirect discards everything queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight_pc <= 32'h0000_0000;
      inflight    <= 1'b0;
      kill        <= 1'b0;
      wr_ptr      <= {PW{1'b0}};
      rd_ptr      <= {PW{1'b0}};
      count       <= {CW{1'b0}};
      for (int i = 0; i < QDEPTH; i++) begin
        q_inst[i] <= 32'h0000_0000;
        q_pc[i]   <= 32'h0000_0000;
      end
    end else if (redirect_valid) begin
      pc       <= redirect_pc & 32'hFFFF_FFFC;
      inflight <= 1'b0;
      kill     <= inflight;
      wr_ptr   <= {PW{1'b0}};
      rd_ptr   <= {PW{1'b0}};
      count    <= {CW{1'b0}};
    end else begin
      kill <= 1'b0;
      if (issue_ok) begin
        inflight    <= 1'b1;
        inflight_pc <= pc;
        pc          <= pc + 32'd4;
      end else begin
        inflight <= 1'b0;
      end
      if (push) begin
        q_inst[wr_ptr] <= mbus_data_q;
        q_pc[wr_ptr]   <= inflight_pc;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Activity state: RUN while fetching or waiting on a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= fetch_en ? RUN : IDLE;
        RUN:     state <= (!fetch_en && !inflight) ? IDLE : RUN;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle-latency SRAM model
// and logs of issued read addresses and accepted instructions.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mbus_read;
  logic        mbus_write;
  logic [11:0] mbus_addr;
  logic [3:0]  mbus_byte_sel;
  logic [31:0] mbus_data_d;
  logic        mbus_ready = 1'b0;
  logic [31:0] mbus_data_q = 32'h0;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] reads [$];
  logic [63:0] acc [$];

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .mbus_read(mbus_read), .mbus_write(mbus_write), .mbus_addr(mbus_addr),
    .mbus_byte_sel(mbus_byte_sel), .mbus_data_d(mbus_data_d),
    .mbus_ready(mbus_ready), .mbus_data_q(mbus_data_q),
    .fetch_en(fetch_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input int a);
    return 32'h13 + 32'(a) * 32'h80;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // SRAM model: response one cycle after the read; also logs traffic
  always @(posedge clk) begin
    mbus_ready  <= mbus_read;
    mbus_data_q <= mbus_read ? word_at(int'(mbus_addr)) : 32'h0;
    if (mbus_read) reads.push_back(mbus_addr);
    if (!rst && inst_valid && inst_ready) acc.push_back({inst_pc, inst});
  end

  // Write-side bus must stay idle; queue never exceeds its depth
  always @(negedge clk) begin
    check_eq("bus_wr_bytesel", {27'd0, mbus_write, mbus_byte_sel}, 32'd0);
    check_eq("bus_data_d", mbus_data_d, 32'd0);
    check_eq("count_bound", {31'd0, (dut.count <= 3'd4)}, 32'd1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic fe, input logic ir);
    rst = 1'b1;
    fetch_en = fe;
    inst_ready = ir;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    tick();
    tick();
    check_eq("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check_eq("rst_inst", inst, 32'd0);
    check_eq("rst_inst_pc", inst_pc, 32'd0);
    check_eq("rst_read", {31'd0, mbus_read}, 32'd0);
    check_eq("rst_addr", {20'd0, mbus_addr}, 32'd0);
    reads.delete();
    acc.delete();
    rst = 1'b0;
    #1;
  endtask

  task automatic check_acc(input string tag, input int idx, input logic [31:0] pc, input logic [31:0] w);
    check_eq({tag, "_present"}, {31'd0, (acc.size() > idx)}, 32'd1);
    if (acc.size() > idx) begin
      check_eq({tag, "_pc"}, acc[idx][63:32], pc);
      check_eq({tag, "_inst"}, acc[idx][31:0], w);
    end
  endtask

  task automatic check_read(input string tag, input int idx, input logic [11:0] a);
    check_eq({tag, "_present"}, {31'd0, (reads.size() > idx)}, 32'd1);
    if (reads.size() > idx) check_eq(tag, {20'd0, reads[idx]}, {20'd0, a});
  endtask

  initial begin
    // Streaming from reset
    do_reset(1'b1, 1'b1);
    check_eq("t1_read_c0", {31'd0, mbus_read}, 32'd1);
    check_eq("t1_addr_c0", {20'd0, mbus_addr}, 32'd0);
    tick();
    check_eq("t1_addr_c1", {20'd0, mbus_addr}, 32'd1);
    check_eq("t1_valid_c1", {31'd0, inst_valid}, 32'd0);
    tick();
    check_eq("t1_valid_c2", {31'd0, inst_valid}, 32'd1);
    check_eq("t1_inst_c2", inst, 32'h13);
    check_eq("t1_pc_c2", inst_pc, 32'h0);
    tick();
    check_eq("t1_inst_c3", inst, 32'h93);
    check_eq("t1_pc_c3", inst_pc, 32'h4);
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      check_read("t1_rd", i, 12'(i));
      check_acc("t1_acc", i, 32'(i * 4), word_at(i));
    end

    // Backpressure: queue fills, then drains in order
    do_reset(1'b1, 1'b0);
    repeat (8) tick();
    check_eq("t2_nreads", reads.size(), 32'd4);
    for (int i = 0; i < 4; i++) check_read("t2_rd", i, 12'(i));
    check_eq("t2_read_stall", {31'd0, mbus_read}, 32'd0);
    check_eq("t2_count", {29'd0, dut.count}, 32'd4);
    check_eq("t2_head_pc", inst_pc, 32'h0);
    check_eq("t2_head_inst", inst, 32'h13);
    reads.delete();
    inst_ready = 1'b1;
    repeat (8) tick();
    check_read("t2_resume", 0, 12'd4);
    for (int i = 0; i < 6; i++) check_acc("t2_acc", i, 32'(i * 4), word_at(i));

    // Redirect with 3 queued and 1 in flight
    do_reset(1'b1, 1'b0);
    repeat (4) tick();
    check_eq("t3_count_pre", {29'd0, dut.count}, 32'd3);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    #1;
    check_eq("t3_read_R", {31'd0, mbus_read}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    inst_ready = 1'b1;
    acc.delete();
    #1;
    check_eq("t3_valid_R1", {31'd0, inst_valid}, 32'd0);
    check_eq("t3_count_R1", {29'd0, dut.count}, 32'd0);
    check_eq("t3_read_R1", {31'd0, mbus_read}, 32'd1);
    check_eq("t3_addr_R1", {20'd0, mbus_addr}, 32'h40);
    tick();
    check_eq("t3_valid_R2", {31'd0, inst_valid}, 32'd0);
    tick();
    check_eq("t3_valid_R3", {31'd0, inst_valid}, 32'd1);
    check_eq("t3_pc_R3", inst_pc, 32'h100);
    check_eq("t3_inst_R3", inst, word_at(32'h40));
    repeat (2) tick();
    check_acc("t3_acc", 0, 32'h100, word_at(32'h40));
    check_acc("t3_acc", 1, 32'h104, word_at(32'h41));

    // Misaligned redirect target, then back-to-back redirects
    do_reset(1'b1, 1'b1);
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0206;
    tick();
    redirect_valid = 1'b0;
    #1;
    check_eq("t4_addr_align", {20'd0, mbus_addr}, 32'h81);
    tick();
    tick();
    check_eq("t4_pc_align", inst_pc, 32'h204);
    check_eq("t4_inst_align", inst, word_at(32'h81));
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    tick();
    redirect_pc = 32'h20;
    tick();
    redirect_valid = 1'b0;
    acc.delete();
    reads.delete();
    repeat (5) tick();
    check_read("t4_rd", 0, 12'h8);
    check_acc("t4_acc", 0, 32'h20, word_at(8));
    check_acc("t4_acc", 1, 32'h24, word_at(9));

    // fetch_en gap of 5 cycles mid-stream
    do_reset(1'b1, 1'b1);
    repeat (3) tick();
    fetch_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("t5_gap_read", {31'd0, mbus_read}, 32'd0);
      tick();
    end
    fetch_en = 1'b1;
    #1;
    check_eq("t5_resume_read", {31'd0, mbus_read}, 32'd1);
    check_eq("t5_resume_addr", {20'd0, mbus_addr}, 32'd3);
    repeat (10) tick();
    for (int i = 0; i < 8; i++) check_acc("t5_acc", i, 32'(i * 4), word_at(i));

    // Asynchronous reset mid-cycle with a full queue
    do_reset(1'b1, 1'b0);
    repeat (8) tick();
    check_eq("t6_full_valid", {31'd0, inst_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6_async_valid", {31'd0, inst_valid}, 32'd0);
    check_eq("t6_async_read", {31'd0, mbus_read}, 32'd0);
    check_eq("t6_async_pc", inst_pc, 32'd0);
    tick();
    reads.delete();
    rst = 1'b0;
    #1;
    check_eq("t6_post_read", {31'd0, mbus_read}, 32'd1);
    check_eq("t6_post_addr", {20'd0, mbus_addr}, 32'd0);
    check_eq("t6_post_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    check_read("t6_rd", 0, 12'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
